// File: rtl/seq_gen_tx.sv
// seq_gen_tx: serial pattern transmitter, MSB-first, with repeat count and
// optional idle gap between repetitions. Stimulus source for a 1101 detector.
module seq_gen_tx #(
  parameter int unsigned      WIDTH   = 4,
  parameter logic [WIDTH-1:0] PATTERN = 4'b1101,
  parameter int unsigned      CNT_W   = 4,
  parameter int unsigned      GAP_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             use_default,
  input  logic [WIDTH-1:0] pattern_in,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap_len,
  input  logic             abort,
  output logic             outp,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]   rep_q, rep_d;
  logic [GAP_W-1:0]   gap_len_q, gap_len_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               outp_q, outp_d;
  logic               bit_valid_q, bit_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // State, datapath and registered-output flops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      rep_q       <= '0;
      gap_len_q   <= '0;
      gap_cnt_q   <= '0;
      outp_q      <= 1'b0;
      bit_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      rep_q       <= rep_d;
      gap_len_q   <= gap_len_d;
      gap_cnt_q   <= gap_cnt_d;
      outp_q      <= outp_d;
      bit_valid_q <= bit_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state and counter/shift-register update; abort overrides everything
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    rep_d     = rep_q;
    gap_len_d = gap_len_q;
    gap_cnt_d = gap_cnt_q;

    if (abort && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      bit_cnt_d = '0;
      rep_d     = '0;
      gap_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            shreg_d   = use_default ? PATTERN : pattern_in;
            rep_d     = (repeat_cnt == '0) ? CNT_W'(1) : repeat_cnt;
            gap_len_d = gap_len;
            bit_cnt_d = '0;
            gap_cnt_d = '0;
            state_d   = S_SHIFT;
          end
        end
        S_SHIFT: begin
          // Rotate so the pattern is restored after WIDTH bits
          shreg_d = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            gap_cnt_d = '0;
            rep_d     = rep_q - CNT_W'(1);
            if (rep_q == CNT_W'(1)) begin
              state_d = S_DONE;
            end else if (gap_len_q != '0) begin
              state_d = S_GAP;
            end else begin
              state_d = S_SHIFT;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
        S_GAP: begin
          if (gap_cnt_q == (gap_len_q - GAP_W'(1))) begin
            gap_cnt_d = '0;
            state_d   = S_SHIFT;
          end else begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Output values registered one cycle behind the state; abort zeroes them at once
  always_comb begin
    outp_d      = 1'b0;
    bit_valid_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    if (!abort) begin
      case (state_q)
        S_SHIFT: begin
          outp_d      = shreg_q[WIDTH-1];
          bit_valid_d = 1'b1;
          busy_d      = 1'b1;
        end
        S_GAP: begin
          busy_d = 1'b1;
        end
        S_DONE: begin
          done_d = 1'b1;
        end
        default: begin
          outp_d = 1'b0;
        end
      endcase
    end
  end

  assign outp      = outp_q;
  assign bit_valid = bit_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_seq_gen_tx.sv
// Directed bench for seq_gen_tx; each cycle compares {outp,bit_valid,busy,done}.
module tb_seq_gen_tx;

  logic       clk;
  logic       reset;
  logic       start;
  logic       use_default;
  logic [3:0] pattern_in;
  logic [3:0] repeat_cnt;
  logic [3:0] gap_len;
  logic       abort;
  logic       outp;
  logic       bit_valid;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  // Expected-vector shorthand: {outp, bit_valid, busy, done}
  localparam logic [3:0] IDLE_V = 4'b0000;
  localparam logic [3:0] ONE_V  = 4'b1110;
  localparam logic [3:0] ZERO_V = 4'b0110;
  localparam logic [3:0] GAP_V  = 4'b0010;
  localparam logic [3:0] DONE_V = 4'b0001;

  seq_gen_tx #(
    .WIDTH   (4),
    .PATTERN (4'b1101),
    .CNT_W   (4),
    .GAP_W   (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .use_default (use_default),
    .pattern_in  (pattern_in),
    .repeat_cnt  (repeat_cnt),
    .gap_len     (gap_len),
    .abort       (abort),
    .outp        (outp),
    .bit_valid   (bit_valid),
    .busy        (busy),
    .done        (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, then compare outputs just after it
  task automatic cyc(input string tag, input logic [3:0] exp);
    @(posedge clk);
    #1;
    chk(tag, {outp, bit_valid, busy, done}, exp);
  endtask

  // Four consecutive pattern bits, MSB first
  task automatic expect_pattern(input string tag, input logic [3:0] pat);
    for (int i = 3; i >= 0; i--) begin
      cyc($sformatf("%s_bit%0d", tag, 3 - i), pat[i] ? ONE_V : ZERO_V);
    end
  endtask

  initial begin
    reset       = 1'b0;
    start       = 1'b0;
    use_default = 1'b0;
    pattern_in  = 4'b0000;
    repeat_cnt  = 4'd0;
    gap_len     = 4'd0;
    abort       = 1'b0;

    // Reset state
    #2;
    chk("reset_outputs", {outp, bit_valid, busy, done}, IDLE_V);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    cyc("idle_after_reset", IDLE_V);

    // Default pattern, single repetition
    start = 1'b1; use_default = 1'b1; repeat_cnt = 4'd1; gap_len = 4'd0;
    cyc("t1_latency", IDLE_V);
    start = 1'b0;
    expect_pattern("t1", 4'b1101);
    cyc("t1_done", DONE_V);
    cyc("t1_idle", IDLE_V);

    // Two repetitions back-to-back: 11011101, done 9 cycles after start
    start = 1'b1; use_default = 1'b1; repeat_cnt = 4'd2; gap_len = 4'd0;
    cyc("t2_latency", IDLE_V);
    start = 1'b0;
    expect_pattern("t2_r0", 4'b1101);
    expect_pattern("t2_r1", 4'b1101);
    cyc("t2_done", DONE_V);
    cyc("t2_idle", IDLE_V);

    // User pattern 1010, two repetitions, gap of 2
    start = 1'b1; use_default = 1'b0; pattern_in = 4'b1010; repeat_cnt = 4'd2; gap_len = 4'd2;
    cyc("t3_latency", IDLE_V);
    start = 1'b0;
    expect_pattern("t3_r0", 4'b1010);
    cyc("t3_gap0", GAP_V);
    cyc("t3_gap1", GAP_V);
    expect_pattern("t3_r1", 4'b1010);
    cyc("t3_done", DONE_V);
    cyc("t3_idle", IDLE_V);

    // repeat_cnt=0 -> one repetition; mid-run start and input changes ignored
    start = 1'b1; use_default = 1'b0; pattern_in = 4'b1001; repeat_cnt = 4'd0; gap_len = 4'd0;
    cyc("t4_latency", IDLE_V);
    start = 1'b0; pattern_in = 4'b0110; repeat_cnt = 4'd3; gap_len = 4'd5;
    cyc("t4_bit0", ONE_V);
    start = 1'b1;
    cyc("t4_bit1", ZERO_V);
    start = 1'b0; pattern_in = 4'b1111;
    cyc("t4_bit2", ZERO_V);
    cyc("t4_bit3", ONE_V);
    cyc("t4_done", DONE_V);
    cyc("t4_idle0", IDLE_V);
    cyc("t4_idle1", IDLE_V);

    // Abort on 3rd bit of repetition 1 of 3
    start = 1'b1; use_default = 1'b1; repeat_cnt = 4'd3; gap_len = 4'd0;
    cyc("t5_latency", IDLE_V);
    start = 1'b0;
    expect_pattern("t5_r0", 4'b1101);
    cyc("t5_r1_bit0", ONE_V);
    cyc("t5_r1_bit1", ONE_V);
    cyc("t5_r1_bit2", ZERO_V);
    abort = 1'b1;
    cyc("t5_abort_idle", IDLE_V);
    abort = 1'b0;
    cyc("t5_no_done0", IDLE_V);
    start = 1'b1; use_default = 1'b1; repeat_cnt = 4'd1; gap_len = 4'd0;
    cyc("t5_restart_latency", IDLE_V);
    start = 1'b0;
    expect_pattern("t5_restart", 4'b1101);
    cyc("t5_restart_done", DONE_V);
    cyc("t5_restart_idle", IDLE_V);

    // Asynchronous reset during GAP
    start = 1'b1; use_default = 1'b1; repeat_cnt = 4'd2; gap_len = 4'd3;
    cyc("t6_latency", IDLE_V);
    start = 1'b0;
    expect_pattern("t6_r0", 4'b1101);
    cyc("t6_gap0", GAP_V);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_reset", {outp, bit_valid, busy, done}, IDLE_V);
    cyc("t6_held_in_reset", IDLE_V);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1; use_default = 1'b1; repeat_cnt = 4'd1; gap_len = 4'd0;
    cyc("t6_restart_latency", IDLE_V);
    start = 1'b0;
    expect_pattern("t6_restart", 4'b1101);
    cyc("t6_restart_done", DONE_V);
    cyc("t6_restart_idle", IDLE_V);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_gen_tx.md
# seq_gen_tx

Serial pattern transmitter: the stimulus-side counterpart of the `seq_dec_2` 1101 sequence detector. It accepts a start command with a parallel pattern and emits the pattern MSB-first on a single-bit serial output, one bit per clock. It can repeat the pattern R times, back-to-back or separated by an idle gap. Its `outp` connects directly to a detector's `inp` for loopback and self-test.

## Interface
- `WIDTH`, 4: pattern length in bits (≥2).
- `PATTERN`, 4'b1101: built-in pattern, used when `use_default`=1.
- `CNT_W`, 4: width of the repeat-count field.
- `GAP_W`, 4: width of the gap-length field.

- `clk`  input  1  clock; all logic on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `start`  input  1  begin a transmission; sampled only in IDLE.
- `use_default`  input  1  1 selects `PATTERN`; 0 selects `pattern_in`; sampled with `start`.
- `pattern_in`  input  WIDTH  user pattern; sampled with `start`.
- `repeat_cnt`  input  CNT_W  number of repetitions; 0 is treated as 1.
- `gap_len`  input  GAP_W  idle cycles between repetitions; 0 means back-to-back.
- `abort`  input  1  synchronous cancel of the current transmission.
- `outp`  output  1  serial data, registered.
- `bit_valid`  output  1  high while `outp` carries a pattern bit.
- `busy`  output  1  high from the first bit through the last bit.
- `done`  output  1  one-cycle pulse after the final bit.

## Operation
- States: IDLE, SHIFT, GAP, DONE. Encode them in 2 bits.
- All outputs are registered.
- Reset value of every output is 0. State resets to IDLE and all counters reset to 0.
- **IDLE**
  - `outp`=0, `bit_valid`=0, `busy`=0.
  - When `start`=1 at an edge, latch:
    - the shift register (`PATTERN` or `pattern_in`);
    - the repetitions-left count (`repeat_cnt`, with 0→1);
    - the gap length.
  - Go to SHIFT.
- **SHIFT**
  - Drive `outp` = current MSB, `bit_valid`=1, `busy`=1.
  - Rotate the shift register left each cycle so the pattern is intact for the next repetition.
  - The bit counter counts 0..WIDTH-1.
  - After bit WIDTH-1, decrement repetitions-left:
    - if it is now 0 → DONE;
    - else if `gap_len`≠0 → GAP;
    - else → SHIFT at bit 0 (no bubble).
- **GAP**
  - `outp`=0, `bit_valid`=0, `busy`=1.
  - Lasts exactly `gap_len` cycles, then → SHIFT.
- **DONE**
  - Lasts one cycle: `done`=1, `busy`=0, `outp`=0.
  - Then → IDLE.
  - `start` is ignored in DONE.
- **`abort`=1 at any edge outside IDLE**
  - Next cycle: IDLE with all outputs 0 and no `done` pulse.
  - `abort` has priority over all transitions.
  - `abort` is ignored in IDLE.
- **`start` outside IDLE** is ignored. Inputs are not re-sampled mid-transmission.
- **`reset` asserted mid-operation** immediately forces IDLE and zeroes all outputs, independent of `clk`.
- **Widths**
  - Bit counter: $clog2(WIDTH).
  - Repeat counter: CNT_W bits.
  - Gap counter: GAP_W bits.
  - No counter wraps in legal operation.

## Timing
- Let `start` be sampled high at edge k, and let R = effective repeat count and G = `gap_len`.
- Bit i of repetition r (r from 0) is on `outp` in the cycle after edge k+1+r·(WIDTH+G)+i.
- Latency from `start` to the first bit is 1 cycle.
- `busy` is high for R·WIDTH+(R-1)·G cycles.
- `done` is high for exactly one cycle, immediately after the last bit.
- The earliest next accepted `start` is at the edge ending the DONE cycle plus one, i.e. in IDLE.
- Minimum period between transmissions: R·WIDTH+(R-1)·G+2 cycles.
- Once `reset` deasserts, the first `start` can be accepted at the next edge.

## Test plan
- Reset, then `start`, `use_default`=1, `repeat_cnt`=1, `gap_len`=0 → `outp` = 1,1,0,1 on 4 consecutive cycles beginning one cycle after `start`. `bit_valid` and `busy` are high for 4 cycles, then `done` pulses once and all outputs return to 0.
- Loopback into `seq_dec_2` with `repeat_cnt`=2, `gap_len`=0 → serial stream 11011101 and two detector `outp` pulses; `done` pulses 9 cycles after `start`.
- `pattern_in`=4'b1010, `use_default`=0, `repeat_cnt`=2, `gap_len`=2 → stream 1010, 0, 0 (`bit_valid`=0 during the gap), 1010. `busy` is high for 10 cycles.
- `repeat_cnt`=0 → exactly one repetition; a `start` pulse during SHIFT is ignored; the pattern and count are unchanged by `pattern_in` toggling mid-transmission.
- `abort` at the 3rd bit of repetition 1 of 3 → IDLE the next cycle, no `done` pulse; a new `start` two cycles later is accepted and runs normally.
- `reset` pulled low asynchronously between clock edges during GAP → all outputs go to 0 immediately. After release, `start` produces a clean 1101.
